sa_result_collector: RTL and testbench
======================================

// Module: sa_result_collector
// PURPOSE
//  Drain-side partner of the systolic-array input feeder. Captures the X_R result row vectors
//  shifted out of the output-stationary PE array, requantises each ACC_W accumulator to D_W,
//  and assembles them into one flat X_R x W_C result matrix for the downstream softmax/attention stage.
// PARAMETERS
//  D_W   16  output element width (fixed point, FRAC fractional bits)
//  ACC_W 32  accumulator element width delivered by the array
//  FRAC  8   right-shift applied to each accumulator before narrowing
//  X_R   16  number of result rows (drain beats per matrix)
//  W_C   16  number of result columns (elements per drain beat)
// PORTS
//  I_CLK        in  1            clock
//  I_ASYN_RSTN  in  1            asynchronous active-low reset
//  I_SYNC_RSTN  in  1            synchronous active-low clear (same effect as reset, on clock edge)
//  I_START      in  1            arm collection of a new matrix
//  I_ROW_VALID  in  1            drain beat present on I_ROW_VECTOR
//  I_ROW_VECTOR in  W_C*ACC_W    one result row; element j at [j*ACC_W +: ACC_W], signed
//  I_ACK        in  1            consumer has taken O_Y_MATRIX
//  O_BUSY       out 1            collecting (state S_COLLECT)
//  O_VALID      out 1            O_Y_MATRIX complete and stable
//  O_SAT        out 1            sticky: at least one element clipped in current matrix
//  O_Y_MATRIX   out X_R*W_C*D_W  element (r,c) at [(r*W_C+c)*D_W +: D_W], signed
// BEHAVIOUR
//  - Reset (async, or sync clear): state=S_IDLE, row_cnt=0, O_BUSY=0, O_VALID=0, O_SAT=0, O_Y_MATRIX=0.
//  - States: S_IDLE -> S_COLLECT on I_START; S_COLLECT -> S_DONE on capture of beat X_R-1;
//    S_DONE -> S_IDLE on I_ACK; S_DONE -> S_COLLECT on I_START (I_START wins over I_ACK).
//  - Entering S_COLLECT: row_cnt=0, O_SAT cleared; O_Y_MATRIX retained (not zeroed) until overwritten.
//  - Drain order mirrors the feeder: beat k (k=0..X_R-1) is written to row X_R-1-k.
//  - Capture: in S_COLLECT, each cycle with I_ROW_VALID=1 registers one beat; row_cnt++. 1-cycle latency:
//    matrix row visible the cycle after the beat. Last beat and O_VALID=1 appear the same cycle.
//  - I_ROW_VALID in S_IDLE or S_DONE: ignored, matrix and flags unchanged.
//  - I_START during S_COLLECT: restart (row_cnt=0, O_SAT=0); a beat in that same cycle is discarded.
//  - I_ACK outside S_DONE: ignored. O_VALID is a level held until leaving S_DONE.
//  - Requantise per element: q = acc >>> FRAC (arithmetic), then narrow to D_W (see CONFIGURATION).
//  - row_cnt width $clog2(X_R+1); never wraps: stops at X_R.
//  - I_SYNC_RSTN low mid-collection: same as reset on next edge; partial matrix discarded.
// CONFIGURATION
//  SA_COLLECT_SAT_EN defined: narrowed value clipped to [-2^(D_W-1), 2^(D_W-1)-1]; any clip sets O_SAT.
//  Undefined: narrowed value = q[D_W-1:0] (two's-complement wrap); O_SAT tied 0.
// STRUCTURE
//  - Shared defines: state encodings (S_IDLE=3'b001, S_COLLECT=3'b010, S_DONE=3'b100),
//    VARIABLE_TO_MATRIX/MATRIX_TO_VARIABLE flattening macros, default D_W/ACC_W/FRAC.
//  - Sub-module sa_out_quant: combinational per-element shift + narrow (+ clip flag), instantiated W_C times.
//  - Top: FSM, row counter, row-write decode, sticky O_SAT register.
// TESTING
//  1 Reset mid-collect: I_ASYN_RSTN low after 5 beats -> all outputs 0, state S_IDLE immediately.
//  2 Full matrix: X_R=16, beat k all elements = (k+1)<<8 -> row 15-k elements = k+1; O_VALID
//    rises same cycle as row 0 written, stays high until I_ACK.
//  3 Gapped valid: beats with 0-3 idle cycles between -> identical matrix to test 2; O_BUSY high throughout.
//  4 Saturation (SAT_EN): element = 32'h7FFF_FFFF -> 16'h7FFF, O_SAT=1; element = 32'h8000_0000 -> 16'h8000;
//    without SAT_EN -> 16'hFFFF / 16'h0000, O_SAT=0. Negative -256 -> 16'hFFFF either way.
//  5 Boundaries: I_ROW_VALID in S_DONE -> matrix unchanged; I_START+I_ACK same cycle in S_DONE ->
//    S_COLLECT, O_VALID=0 next cycle; I_START in S_COLLECT with beat -> beat dropped, row_cnt=0.
//  6 Sync clear: I_SYNC_RSTN low one cycle in S_DONE -> outputs zero next edge, I_ACK no longer needed.

Source files
------------

// File: rtl/sa_result_collector_pkg.sv
// ---------------------------------------------------------------------------------------------
// sa_result_collector_pkg
//   Shared definitions for the systolic-array result collector: default geometry, the one-hot
//   FSM state encoding and a helper that locates an element inside the flat result matrix.
//   Configuration macro: SA_COLLECT_SAT_EN (see sa_out_quant).
// ---------------------------------------------------------------------------------------------
package sa_result_collector_pkg;

   localparam int unsigned DefDw   = 16;
   localparam int unsigned DefAccW = 32;
   localparam int unsigned DefFrac = 8;
   localparam int unsigned DefXr   = 16;
   localparam int unsigned DefWc   = 16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'b001,
      S_COLLECT = 3'b010,
      S_DONE    = 3'b100
   } state_e;

   // LSB position of element (r,c) in a row-major flattened X_R x W_C matrix of d_w-bit elements.
   function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c,
                                            input int unsigned w_c, input int unsigned d_w);
      return (r * w_c + c) * d_w;
   endfunction

endpackage

// File: rtl/sa_out_quant.sv
// ---------------------------------------------------------------------------------------------
// sa_out_quant
//   Combinational requantiser for one accumulator element: arithmetic right shift by FRAC,
//   then narrowing to D_W bits.
//   SA_COLLECT_SAT_EN defined : out-of-range values clip to the signed D_W limits, sat_o flags it.
//   SA_COLLECT_SAT_EN undefined: two's-complement wrap (low D_W bits), sat_o tied 0.
// Ports
//   acc_i  in  ACC_W  signed accumulator
//   q_o    out D_W    requantised element
//   sat_o  out 1      element was clipped
// ---------------------------------------------------------------------------------------------
module sa_out_quant #(
   parameter int unsigned D_W   = 16,
   parameter int unsigned ACC_W = 32,
   parameter int unsigned FRAC  = 8
) (
   input  logic [ACC_W-1:0] acc_i,
   output logic [D_W-1:0]   q_o,
   output logic             sat_o
);

   logic signed [ACC_W-1:0] shifted;

   assign shifted = $signed(acc_i) >>> FRAC;

`ifdef SA_COLLECT_SAT_EN
   logic fits;

   // Value fits in D_W signed bits iff every bit from the D_W sign bit upward agrees.
   assign fits = (&shifted[ACC_W-1:D_W-1]) | ~(|shifted[ACC_W-1:D_W-1]);

   always_comb begin
      q_o   = shifted[D_W-1:0];
      sat_o = 1'b0;
      if (!fits) begin
         sat_o = 1'b1;
         q_o   = shifted[ACC_W-1] ? {1'b1, {(D_W-1){1'b0}}} : {1'b0, {(D_W-1){1'b1}}};
      end
   end
`else
   logic unused_hi;

   assign unused_hi = ^shifted[ACC_W-1:D_W];
   assign q_o       = shifted[D_W-1:0];
   assign sat_o     = 1'b0;
`endif

endmodule

// File: rtl/sa_result_collector.sv
// ---------------------------------------------------------------------------------------------
// sa_result_collector
//   Drain-side partner of the systolic-array feeder. Captures X_R row beats of W_C accumulators,
//   requantises each element to D_W bits and assembles a flat X_R x W_C result matrix.
//   Beat k lands in row X_R-1-k (mirrors the feeder's drain order).
//   Configuration macro: SA_COLLECT_SAT_EN enables clipping and the sticky O_SAT flag.
// Ports
//   I_CLK        in  1            clock
//   I_ASYN_RSTN  in  1            asynchronous active-low reset
//   I_SYNC_RSTN  in  1            synchronous active-low clear
//   I_START      in  1            arm collection of a new matrix (also restarts a collection)
//   I_ROW_VALID  in  1            drain beat present
//   I_ROW_VECTOR in  W_C*ACC_W    one result row, element j at [j*ACC_W +: ACC_W]
//   I_ACK        in  1            consumer has taken the matrix
//   O_BUSY       out 1            collecting
//   O_VALID      out 1            matrix complete and stable
//   O_SAT        out 1            sticky clip flag for the current matrix
//   O_Y_MATRIX   out X_R*W_C*D_W  element (r,c) at [(r*W_C+c)*D_W +: D_W]
// ---------------------------------------------------------------------------------------------
module sa_result_collector
   import sa_result_collector_pkg::*;
#(
   parameter int unsigned D_W   = DefDw,
   parameter int unsigned ACC_W = DefAccW,
   parameter int unsigned FRAC  = DefFrac,
   parameter int unsigned X_R   = DefXr,
   parameter int unsigned W_C   = DefWc
) (
   input  logic                   I_CLK,
   input  logic                   I_ASYN_RSTN,
   input  logic                   I_SYNC_RSTN,
   input  logic                   I_START,
   input  logic                   I_ROW_VALID,
   input  logic [W_C*ACC_W-1:0]   I_ROW_VECTOR,
   input  logic                   I_ACK,
   output logic                   O_BUSY,
   output logic                   O_VALID,
   output logic                   O_SAT,
   output logic [X_R*W_C*D_W-1:0] O_Y_MATRIX
);

   localparam int unsigned CntW = $clog2(X_R + 1);
   localparam int unsigned RowW = W_C * D_W;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        row_cnt_q, row_cnt_d;
   logic [X_R*RowW-1:0]    mat_q, mat_d;
   logic                   sat_q, sat_d;
   logic [RowW-1:0]        qrow;
   logic [W_C-1:0]         clip;
   logic [CntW-1:0]        row_idx;

   for (genvar j = 0; j < W_C; j++) begin : g_quant
      sa_out_quant #(
         .D_W   (D_W),
         .ACC_W (ACC_W),
         .FRAC  (FRAC)
      ) u_quant (
         .acc_i (I_ROW_VECTOR[j*ACC_W +: ACC_W]),
         .q_o   (qrow[j*D_W +: D_W]),
         .sat_o (clip[j])
      );
   end

   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      mat_d     = mat_q;
      sat_d     = sat_q;
      row_idx   = CntW'(X_R - 1) - row_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (I_START) begin
               state_d   = S_COLLECT;
               row_cnt_d = '0;
               sat_d     = 1'b0;
            end
         end
         S_COLLECT: begin
            // A restart takes priority; any beat in the same cycle is dropped.
            if (I_START) begin
               row_cnt_d = '0;
               sat_d     = 1'b0;
            end else if (I_ROW_VALID && (row_cnt_q < CntW'(X_R))) begin
               for (int unsigned r = 0; r < X_R; r++) begin
                  if (row_idx == CntW'(r)) begin
                     mat_d[elem_lsb(r, 0, W_C, D_W) +: RowW] = qrow;
                  end
               end
               row_cnt_d = row_cnt_q + 1'b1;
               sat_d     = sat_q | (|clip);
               if (row_cnt_q == CntW'(X_R - 1)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (I_START) begin
               state_d   = S_COLLECT;
               row_cnt_d = '0;
               sat_d     = 1'b0;
            end else if (I_ACK) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            row_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
      if (!I_ASYN_RSTN) begin
         state_q   <= S_IDLE;
         row_cnt_q <= '0;
         mat_q     <= '0;
         sat_q     <= 1'b0;
      end else if (!I_SYNC_RSTN) begin
         state_q   <= S_IDLE;
         row_cnt_q <= '0;
         mat_q     <= '0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         mat_q     <= mat_d;
         sat_q     <= sat_d;
      end
   end

   assign O_BUSY     = (state_q == S_COLLECT);
   assign O_VALID    = (state_q == S_DONE);
   assign O_SAT      = sat_q;
   assign O_Y_MATRIX = mat_q;

endmodule

// File: tb/tb_sa_result_collector.sv
// Testbench for sa_result_collector: quantisation table, directed corner sequences and a
// randomized run, all checked against a matrix-level reference model.
module tb_sa_result_collector;

   localparam int D_W   = 16;
   localparam int ACC_W = 32;
   localparam int FRAC  = 8;
   localparam int X_R   = 16;
   localparam int W_C   = 16;
   localparam int VW    = W_C * ACC_W;
   localparam int MW    = X_R * W_C * D_W;

   logic          clk = 1'b0;
   logic          arstn, srstn, start, rvalid, ack;
   logic [VW-1:0] vec;
   logic          busy, valid, sat;
   logic [MW-1:0] ymat;

   always #5 clk = ~clk;

   sa_result_collector #(
      .D_W   (D_W),
      .ACC_W (ACC_W),
      .FRAC  (FRAC),
      .X_R   (X_R),
      .W_C   (W_C)
   ) dut (
      .I_CLK        (clk),
      .I_ASYN_RSTN  (arstn),
      .I_SYNC_RSTN  (srstn),
      .I_START      (start),
      .I_ROW_VALID  (rvalid),
      .I_ROW_VECTOR (vec),
      .I_ACK        (ack),
      .O_BUSY       (busy),
      .O_VALID      (valid),
      .O_SAT        (sat),
      .O_Y_MATRIX   (ymat)
   );

   int nvec = 0;
   int nerr = 0;

   // Reference model: the result matrix as a 2-D array plus collection bookkeeping.
   logic [15:0] m [X_R][W_C];
   bit          m_collecting, m_complete, m_sat;
   int          m_beats;

   typedef struct {
      logic [31:0] acc;
      logic [15:0] q;
      logic        clipped;
   } qvec_t;

   qvec_t tbl [10];

   function automatic logic [15:0] quant(input logic [31:0] a, output bit clipped);
      int q;
      q       = $signed(a) >>> FRAC;
      clipped = 1'b0;
`ifdef SA_COLLECT_SAT_EN
      if (q > 32767) begin
         clipped = 1'b1;
         return 16'h7FFF;
      end
      if (q < -32768) begin
         clipped = 1'b1;
         return 16'h8000;
      end
`endif
      return q[15:0];
   endfunction

   function automatic logic [15:0] el(input logic [MW-1:0] mat, input int r, input int c);
      return mat[(r * W_C + c) * D_W +: D_W];
   endfunction

   function automatic logic [VW-1:0] rowvec(input logic [31:0] v);
      logic [VW-1:0] rv;
      for (int j = 0; j < W_C; j++) rv[j*ACC_W +: ACC_W] = v;
      return rv;
   endfunction

   function automatic logic [VW-1:0] randvec();
      logic [VW-1:0] rv;
      logic [31:0]   r;
      for (int j = 0; j < W_C; j++) begin
         r = $urandom;
         if ($urandom_range(0, 2) != 0) r = {{8{r[23]}}, r[23:0]};
         rv[j*ACC_W +: ACC_W] = r;
      end
      return rv;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < X_R; r++)
         for (int c = 0; c < W_C; c++) m[r][c] = 16'h0000;
      m_collecting = 1'b0;
      m_complete   = 1'b0;
      m_sat        = 1'b0;
      m_beats      = 0;
   endtask

   task automatic model_edge(input bit st, input bit rv, input logic [VW-1:0] v, input bit ak,
                             input bit sr);
      bit cl;
      if (sr) begin
         model_reset();
      end else if (st) begin
         m_collecting = 1'b1;
         m_complete   = 1'b0;
         m_beats      = 0;
         m_sat        = 1'b0;
      end else if (m_collecting && rv) begin
         for (int c = 0; c < W_C; c++) begin
            m[X_R - 1 - m_beats][c] = quant(v[c*ACC_W +: ACC_W], cl);
            if (cl) m_sat = 1'b1;
         end
         m_beats++;
         if (m_beats == X_R) begin
            m_collecting = 1'b0;
            m_complete   = 1'b1;
         end
      end else if (m_complete && ak) begin
         m_complete = 1'b0;
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      int bad_r, bad_c;
      bad_r = -1;
      bad_c = -1;
      chk1({tag, " busy"}, busy, m_collecting);
      chk1({tag, " valid"}, valid, m_complete);
      chk1({tag, " sat"}, sat, m_sat);
      for (int r = 0; r < X_R; r++)
         for (int c = 0; c < W_C; c++)
            if (bad_r < 0 && el(ymat, r, c) !== m[r][c]) begin
               bad_r = r;
               bad_c = c;
            end
      nvec++;
      if (bad_r >= 0) begin
         nerr++;
         $display("FAIL %s matrix: element (%0d,%0d) got %h expected %h (t=%0t)", tag, bad_r,
                  bad_c, el(ymat, bad_r, bad_c), m[bad_r][bad_c], $time);
      end
   endtask

   task automatic cycle(input bit st, input bit rv, input logic [VW-1:0] v, input bit ak,
                        input bit sr, input string tag);
      start  = st;
      rvalid = rv;
      vec    = v;
      ack    = ak;
      srstn  = ~sr;
      model_edge(st, rv, v, ak, sr);
      @(posedge clk);
      #1;
      chk_model(tag);
   endtask

   task automatic idle(input string tag);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      logic [VW-1:0] zero_v;
      zero_v = '0;

      tbl[0] = '{32'h7FFF_FFFF, 16'hFFFF, 1'b0};
      tbl[1] = '{32'h8000_0000, 16'h0000, 1'b0};
      tbl[2] = '{32'hFFFF_FF00, 16'hFFFF, 1'b0};
      tbl[3] = '{32'h0000_0100, 16'h0001, 1'b0};
      tbl[4] = '{32'h0001_2345, 16'h0123, 1'b0};
      tbl[5] = '{32'h007F_FF00, 16'h7FFF, 1'b0};
      tbl[6] = '{32'h0080_0000, 16'h8000, 1'b0};
      tbl[7] = '{32'hFF80_0000, 16'h8000, 1'b0};
      tbl[8] = '{32'hFF7F_FF00, 16'h7FFF, 1'b0};
      tbl[9] = '{32'h0000_00FF, 16'h0000, 1'b0};
`ifdef SA_COLLECT_SAT_EN
      tbl[0] = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1};
      tbl[1] = '{32'h8000_0000, 16'h8000, 1'b1};
      tbl[6] = '{32'h0080_0000, 16'h7FFF, 1'b1};
      tbl[8] = '{32'hFF7F_FF00, 16'h8000, 1'b1};
`endif

      arstn  = 1'b0;
      srstn  = 1'b1;
      start  = 1'b0;
      rvalid = 1'b0;
      ack    = 1'b0;
      vec    = '0;
      model_reset();
      #12;
      chk_model("reset");
      @(posedge clk);
      #1;
      arstn = 1'b1;
      idle("post-reset idle");

      // Quantisation table: fill a whole matrix with one value, inspect corners and O_SAT.
      for (int t = 0; t < 10; t++) begin
         cycle(1'b1, 1'b0, zero_v, 1'b0, 1'b0, "tbl start");
         for (int k = 0; k < X_R; k++) cycle(1'b0, 1'b1, rowvec(tbl[t].acc), 1'b0, 1'b0, "tbl beat");
         chk16($sformatf("tbl%0d elem00", t), el(ymat, 0, 0), tbl[t].q);
         chk16($sformatf("tbl%0d elemFF", t), el(ymat, X_R - 1, W_C - 1), tbl[t].q);
         chk1($sformatf("tbl%0d sat", t), sat, tbl[t].clipped);
         chk1($sformatf("tbl%0d valid", t), valid, 1'b1);
         cycle(1'b0, 1'b0, zero_v, 1'b1, 1'b0, "tbl ack");
      end

      // Asynchronous reset after 5 beats of a collection.
      cycle(1'b1, 1'b0, zero_v, 1'b0, 1'b0, "arst start");
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, randvec(), 1'b0, 1'b0, "arst beat");
      #2;
      arstn = 1'b0;
      #1;
      model_reset();
      chk_model("arst immediate");
      chk16("arst row15", el(ymat, X_R - 1, 0), 16'h0000);
      @(posedge clk);
      #1;
      chk_model("arst held");
      arstn = 1'b1;
      idle("arst release");

      // Full matrix, beat k = (k+1)<<8 everywhere -> row 15-k holds k+1.
      cycle(1'b1, 1'b0, zero_v, 1'b0, 1'b0, "full start");
      for (int k = 0; k < X_R; k++) begin
         cycle(1'b0, 1'b1, rowvec(32'(k + 1) << 8), 1'b0, 1'b0, "full beat");
         chk16($sformatf("full row%0d", X_R - 1 - k), el(ymat, X_R - 1 - k, 3), 16'(k + 1));
         chk1($sformatf("full valid k%0d", k), valid, (k == X_R - 1));
      end
      for (int i = 0; i < 3; i++) begin
         idle("full hold");
         chk1("full valid held", valid, 1'b1);
      end
      cycle(1'b0, 1'b0, zero_v, 1'b1, 1'b0, "full ack");
      chk1("full valid after ack", valid, 1'b0);

      // Gapped drain gives the same matrix; busy stays high throughout.
      cycle(1'b1, 1'b0, zero_v, 1'b0, 1'b0, "gap start");
      for (int k = 0; k < X_R; k++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            idle("gap idle");
            chk1("gap busy", busy, 1'b1);
         end
         cycle(1'b0, 1'b1, rowvec(32'(k + 1) << 8), 1'b0, 1'b0, "gap beat");
      end
      for (int r = 0; r < X_R; r++)
         chk16($sformatf("gap row%0d", r), el(ymat, r, 7), 16'(X_R - r));

      // Beat while done is ignored.
      cycle(1'b0, 1'b1, rowvec(32'h0000_5500), 1'b0, 1'b0, "done beat");
      chk16("done beat ignored", el(ymat, 0, 0), 16'h0010);

      // Start and ack together in done: start wins.
      cycle(1'b1, 1'b0, zero_v, 1'b1, 1'b0, "start+ack");
      chk1("start+ack busy", busy, 1'b1);
      chk1("start+ack valid", valid, 1'b0);

      // Restart with a beat in the same cycle: beat dropped, count restarts.
      cycle(1'b0, 1'b1, rowvec(32'h0000_1100), 1'b0, 1'b0, "rs beatA");
      cycle(1'b0, 1'b1, rowvec(32'h0000_2200), 1'b0, 1'b0, "rs beatB");
      cycle(1'b1, 1'b1, rowvec(32'h0000_3300), 1'b0, 1'b0, "rs start+beat");
      cycle(1'b0, 1'b1, rowvec(32'h0000_4400), 1'b0, 1'b0, "rs beatD");
      chk16("rs row15", el(ymat, X_R - 1, 0), 16'h0044);
      chk16("rs row14", el(ymat, X_R - 2, 0), 16'h0022);
      for (int k = 1; k < X_R; k++) cycle(1'b0, 1'b1, randvec(), 1'b0, 1'b0, "rs fill");
      chk1("rs valid", valid, 1'b1);

      // Synchronous clear while done.
      cycle(1'b0, 1'b0, zero_v, 1'b0, 1'b1, "sclr");
      chk1("sclr valid", valid, 1'b0);
      chk16("sclr elem", el(ymat, X_R - 1, 0), 16'h0000);
      idle("sclr after");
      chk1("sclr busy", busy, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6), randvec(),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 199) == 0), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
